// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared types and default dimensions for the MNIST datapath
package mnist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        LOAD,
        OUT
    } dense_state_e;

    localparam int DENSE1_IN_DIM   = 784;
    localparam int DENSE1_OUT_DIM  = 128;
    localparam int DENSE2_OUT_DIM  = 10;
    localparam int MAC_LAT_DEFAULT = 2;

    // Counter width that stays legal (>=1) for tiny or zero ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elem_counter.sv
// rtl/elem_counter.sv - up-counter with enable, clear and terminal-count flag
module elem_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == MAX_V);

    // Wraps to zero on the terminal count so the next run starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dense_layer_ctrl.sv
// rtl/dense_layer_ctrl.sv - dense layer sequencer; DENSE_CTRL_PERF_EN adds stall/cycle counters
module dense_layer_ctrl
    import mnist_pkg::*;
#(
    parameter int IN_DIM  = DENSE1_IN_DIM,
    parameter int MAC_LAT = MAC_LAT_DEFAULT,
    parameter int ADDR_W  = $clog2(IN_DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_mac_en,
    output logic              o_acc_clr,
    output logic              o_rf_load,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
`ifdef DENSE_CTRL_PERF_EN
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_cycle_cnt,
`endif
    output logic              o_done
);

    localparam int DRAIN_W = cnt_width(MAC_LAT);
    localparam int DRAIN_MAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    dense_state_e        state_q;
    dense_state_e        state_d;
    logic                start_acc;
    logic                handshake;
    logic                elem_last;
    logic                drain_last;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                drain_cnt_unused;

    assign start_acc = !rst && (state_q == IDLE) && i_start;
    assign handshake = !rst && (state_q == ACCUM) && i_valid;

    assign o_ready   = (state_q == ACCUM);
    assign o_mac_en  = handshake;
    assign o_acc_clr = start_acc;
    assign o_rf_load = (state_q == LOAD);
    assign o_valid   = (state_q == OUT);
    assign o_busy    = (state_q != IDLE);
    assign o_done    = !rst && (state_q == OUT) && i_ready;

    elem_counter #(.WIDTH(ADDR_W), .MAX(IN_DIM - 1)) u_elem_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (handshake),
        .cnt (o_w_addr),
        .tc  (elem_last)
    );

    elem_counter #(.WIDTH(DRAIN_W), .MAX(DRAIN_MAX)) u_drain_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (state_q == DRAIN),
        .cnt (drain_cnt),
        .tc  (drain_last)
    );

    assign drain_cnt_unused = ^drain_cnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ACCUM;
            ACCUM:   if (handshake && elem_last) state_d = (MAC_LAT == 0) ? LOAD : DRAIN;
            DRAIN:   if (drain_last) state_d = LOAD;
            LOAD:    state_d = OUT;
            OUT:     if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DENSE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic        stall_hit;

    assign stall_hit   = ((state_q == ACCUM) && !i_valid) || ((state_q == OUT) && !i_ready);
    assign o_stall_cnt = stall_q;
    assign o_cycle_cnt = cycle_q;

    always_comb begin
        stall_d = stall_q;
        cycle_d = cycle_q;
        if (start_acc) begin
            stall_d = '0;
            cycle_d = '0;
        end else begin
            if (stall_hit && (stall_q != '1)) stall_d = stall_q + 32'd1;
            if ((state_q != IDLE) && (cycle_q != '1)) cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            cycle_q <= '0;
        end else begin
            stall_q <= stall_d;
            cycle_q <= cycle_d;
        end
    end
`endif

endmodule

// File: doc/dense_layer_ctrl.md
Name: dense_layer_ctrl

Overview:
Sequencer for one fully-connected layer of the MNIST datapath. Accepts a per-image start, streams IN_DIM input activations through the MAC array with a valid/ready handshake, and drives the weight-ROM address and MAC enable. It waits out the MAC pipeline, then pulses the load strobe of the downstream accumulator register file. It holds an output-valid handshake until the next layer accepts the result.

Parameters:
IN_DIM, 784, input elements per image (>=2)
MAC_LAT, 2, MAC pipeline depth in cycles from o_mac_en to accumulator updated (>=0)
ADDR_W, $clog2(IN_DIM), weight address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_start  in  1  begin one image; honoured only in IDLE
i_valid  in  1  upstream activation valid
o_ready  out  1  controller can take an activation
o_w_addr  out  ADDR_W  weight ROM address = index of current element
o_mac_en  out  1  MAC consumes current activation this cycle
o_acc_clr  out  1  clear accumulators
o_rf_load  out  1  load strobe to accumulator register file (its i_valid)
o_valid  out  1  layer result in register file is valid
i_ready  in  1  next layer accepts result
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse on result handoff

Behaviour:
- Reset: state=IDLE, elem_cnt=0, drain_cnt=0. All outputs 0 in the cycle after reset, and throughout a reset held over several cycles. Reset mid-operation aborts the image with no o_rf_load and no o_done.
- States: IDLE, ACCUM, DRAIN, LOAD, OUT.
- IDLE: o_ready=0.
  - i_start=1: o_acc_clr=1 combinationally that cycle; elem_cnt<=0; next ACCUM.
  - i_start outside IDLE is ignored.
- ACCUM:
  - o_ready=1; o_w_addr=elem_cnt (registered).
  - o_mac_en = i_valid & o_ready, same cycle, zero latency.
  - On handshake, elem_cnt<=elem_cnt+1. If elem_cnt==IN_DIM-1, elem_cnt<=0 and next DRAIN, or LOAD if MAC_LAT==0.
  - i_valid low: hold state, no enable, address stable.
- DRAIN: o_ready=0; drain_cnt counts 0..MAC_LAT-1; after MAC_LAT cycles, next LOAD.
- LOAD: o_rf_load=1 for exactly one cycle; next OUT.
- OUT:
  - o_valid=1 until i_ready=1.
  - On o_valid&i_ready: o_done=1 that cycle, next IDLE.
  - o_valid must not drop without i_ready.
- Latency: start to first o_ready = 1 cycle. Last activation handshake to o_rf_load = MAC_LAT+1 cycles. o_rf_load to o_valid = 1 cycle.
- o_w_addr never exceeds IN_DIM-1; elem_cnt wraps to 0 at image end.
- o_acc_clr and o_mac_en are never high in the same cycle.
- o_busy=1 in every state except IDLE.

Optional Feature:
DENSE_CTRL_PERF_EN:
- Defined: adds outputs o_stall_cnt[31:0] and o_cycle_cnt[31:0].
  - o_stall_cnt counts ACCUM cycles with i_valid=0, plus OUT cycles with i_ready=0.
  - o_cycle_cnt counts all non-IDLE cycles.
  - Both clear on the i_start that is accepted in IDLE and on rst; both saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mnist_pkg:
  - state enum dense_state_e {IDLE, ACCUM, DRAIN, LOAD, OUT}
  - default layer dimensions (784, 128, 10)
  - MAC_LAT default constant
- Sub-module elem_counter: parameterised up-counter with enable, clear and terminal-count flag, used for both elem_cnt and drain_cnt. FSM stays in the top module.

Test Plan:
- IN_DIM=4, MAC_LAT=2, continuous i_valid, i_ready=1:
  - o_acc_clr on the start cycle.
  - o_mac_en for 4 cycles with o_w_addr 0,1,2,3.
  - o_rf_load 3 cycles after the last enable.
  - o_valid and o_done the following cycle, then IDLE.
- Same config, i_valid toggling 1,0,1,0: o_mac_en only on valid cycles; o_w_addr holds during gaps; exactly 4 enables total.
- Backpressure: i_ready=0 for 5 cycles in OUT -> o_valid stays 1, o_done only in the cycle i_ready rises, no second o_rf_load.
- MAC_LAT=0: o_rf_load in the cycle after the last handshake, with no DRAIN cycle.
- rst asserted after 2 accepted elements -> next cycle all outputs 0, IDLE. A new i_start restarts with o_w_addr=0 and o_acc_clr=1.
- i_start pulsed during ACCUM and OUT -> ignored; exactly one o_rf_load and one o_done per accepted start.
